// File: rtl/sim_run_controller_if.sv
// Handshake bundle between the run controller and the CPU test system:
// trap/done flow in, reset control and the verdict flow out.
interface sim_run_controller_if #(
  parameter int NTRAPS = 1,
  parameter int CNT_W  = 32
);
  localparam int TID_W = (NTRAPS > 1) ? $clog2(NTRAPS) : 1;

  logic [NTRAPS-1:0] trap;
  logic              done;
  logic              cpu_reset;
  logic              running;
  logic              finished;
  logic [1:0]        status;
  logic [TID_W-1:0]  trap_id;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output trap, done,
    input  cpu_reset, running, finished, status, trap_id, cycle_count
  );

  modport slave (
    input  trap, done,
    output cpu_reset, running, finished, status, trap_id, cycle_count
  );
endinterface

// File: rtl/sim_run_controller.sv
// Run controller: sequences CPU reset, counts run cycles, watches traps/done,
// enforces a timeout and latches a sticky pass/trap/timeout verdict.
module sim_run_controller #(
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 38,
  parameter int DRAIN_CYCLES   = 1,
  parameter int NTRAPS         = 1,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  sim_run_controller_if.slave  bus
);

  localparam int TID_W = (NTRAPS > 1) ? $clog2(NTRAPS) : 1;

  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FINAL = 2'd3;

  localparam logic [1:0] STATUS_NONE    = 2'd0;
  localparam logic [1:0] STATUS_PASS    = 2'd1;
  localparam logic [1:0] STATUS_TRAP    = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  localparam logic [31:0] HOLD_LAST  = (RESET_CYCLES > 0) ? 32'(RESET_CYCLES - 1) : '0;
  localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam bit DRAIN_EN   = (DRAIN_CYCLES != 0);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [31:0]       hold_cnt;
  logic [31:0]       hold_nx;
  logic [31:0]       drain_cnt;
  logic [31:0]       drain_nx;
  logic [NTRAPS-1:0] trap_q;
  logic [NTRAPS-1:0] trap_edge;
  logic              edge_any;
  logic [TID_W-1:0]  edge_id;
  logic              edge_found;

  logic              cpu_reset_q;
  logic              running_q;
  logic              finished_q;
  logic [1:0]        status_q;
  logic [1:0]        status_nx;
  logic [TID_W-1:0]  trap_id_q;
  logic [TID_W-1:0]  trap_id_nx;
  logic [CNT_W-1:0]  cycle_count_q;
  logic [CNT_W-1:0]  cycle_count_nx;
  logic              count_en;

  // Only rising trap edges count; a level already high out of HOLD is ignored.
  assign trap_edge = bus.trap & ~trap_q;
  assign edge_any  = |trap_edge;

  always_comb begin
    edge_id    = '0;
    edge_found = 1'b0;
    for (int unsigned i = 0; i < NTRAPS; i++) begin
      if (trap_edge[i] && !edge_found) begin
        edge_found = 1'b1;
        edge_id    = TID_W'(i);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    drain_nx   = drain_cnt;
    status_nx  = status_q;
    trap_id_nx = trap_id_q;
    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx = RUN;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + 32'd1;
        end
      end
      RUN: begin
        if (edge_any) begin
          status_nx  = STATUS_TRAP;
          trap_id_nx = edge_id;
          state_nx   = DRAIN_EN ? DRAIN : FINAL;
          drain_nx   = '0;
        end else if (bus.done) begin
          status_nx = STATUS_PASS;
          state_nx  = FINAL;
        end else if (TIMEOUT_EN && (cycle_count_q == TIMEOUT_LAST)) begin
          status_nx = STATUS_TIMEOUT;
          state_nx  = FINAL;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nx = FINAL;
        end else begin
          drain_nx = drain_cnt + 32'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // The edge that leaves RUN/DRAIN for FINAL does not count, so a timeout
  // freezes at TIMEOUT_CYCLES-1 and a done pulse freezes at its own cycle.
  always_comb begin
    count_en = ((state == RUN) || (state == DRAIN)) &&
               ((state_nx == RUN) || (state_nx == DRAIN));
    cycle_count_nx = cycle_count_q;
    if (count_en && (cycle_count_q != '1)) begin
      cycle_count_nx = cycle_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      drain_cnt     <= '0;
      trap_q        <= '0;
      cpu_reset_q   <= 1'b1;
      running_q     <= 1'b0;
      finished_q    <= 1'b0;
      status_q      <= STATUS_NONE;
      trap_id_q     <= '0;
      cycle_count_q <= '0;
    end else begin
      state         <= state_nx;
      hold_cnt      <= hold_nx;
      drain_cnt     <= drain_nx;
      trap_q        <= bus.trap;
      cpu_reset_q   <= (state_nx == HOLD) || (state_nx == FINAL);
      running_q     <= (state_nx == RUN) || (state_nx == DRAIN);
      finished_q    <= (state_nx == FINAL);
      status_q      <= status_nx;
      trap_id_q     <= trap_id_nx;
      cycle_count_q <= cycle_count_nx;
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.running     = running_q;
  assign bus.finished    = finished_q;
  assign bus.status      = status_q;
  assign bus.trap_id     = trap_id_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: several parameterisations share one
// clock and reset; each scenario task checks one instance against hand values.
module tb_sim_run_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sim_run_controller_if #(.NTRAPS(2), .CNT_W(32)) if_a ();
  sim_run_controller_if #(.NTRAPS(1), .CNT_W(32)) if_b ();
  sim_run_controller_if #(.NTRAPS(1), .CNT_W(4))  if_c ();
  sim_run_controller_if #(.NTRAPS(1), .CNT_W(32)) if_d ();
  sim_run_controller_if #(.NTRAPS(2), .CNT_W(32)) if_e ();

  sim_run_controller #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(38), .DRAIN_CYCLES(1),
                       .NTRAPS(2), .CNT_W(32))
    u_a (.clk(clk), .reset(rst), .bus(if_a));
  sim_run_controller #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(0), .DRAIN_CYCLES(1),
                       .NTRAPS(1), .CNT_W(32))
    u_b (.clk(clk), .reset(rst), .bus(if_b));
  sim_run_controller #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(0), .DRAIN_CYCLES(1),
                       .NTRAPS(1), .CNT_W(4))
    u_c (.clk(clk), .reset(rst), .bus(if_c));
  sim_run_controller #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(38), .DRAIN_CYCLES(0),
                       .NTRAPS(1), .CNT_W(32))
    u_d (.clk(clk), .reset(rst), .bus(if_d));
  sim_run_controller #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(38), .DRAIN_CYCLES(3),
                       .NTRAPS(2), .CNT_W(32))
    u_e (.clk(clk), .reset(rst), .bus(if_e));

  // Flags packed as {cpu_reset, running, finished, status[1:0]}.
  task automatic start_run();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] f;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b10000 || if_a.trap_id !== 1'b0 || if_a.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_values flags=%b id=%0d cnt=%0d exp flags=10000 id=0 cnt=0",
               f, if_a.trap_id, if_a.cycle_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.cpu_reset !== 1'b1 || if_a.running !== 1'b0) begin
      failures++;
      $display("FAIL hold_cycle1 cpu_reset=%b running=%b exp cpu_reset=1 running=0",
               if_a.cpu_reset, if_a.running);
    end
    @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b01000 || if_a.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL run_entry flags=%b cnt=%0d exp flags=01000 cnt=0", f, if_a.cycle_count);
    end
  endtask

  task automatic test_done();
    logic [4:0] f;
    start_run();
    repeat (5) @(negedge clk);
    checks++;
    if (if_a.cycle_count !== 32'd5 || if_a.finished !== 1'b0) begin
      failures++;
      $display("FAIL done_pre cnt=%0d fin=%b exp cnt=5 fin=0", if_a.cycle_count, if_a.finished);
    end
    if_a.done = 1'b1;
    @(negedge clk);
    if_a.done = 1'b0;
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b10101 || if_a.cycle_count !== 32'd5) begin
      failures++;
      $display("FAIL done_verdict flags=%b cnt=%0d exp flags=10101 cnt=5", f, if_a.cycle_count);
    end
    repeat (3) @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b10101 || if_a.cycle_count !== 32'd5) begin
      failures++;
      $display("FAIL done_sticky flags=%b cnt=%0d exp flags=10101 cnt=5", f, if_a.cycle_count);
    end
  endtask

  task automatic test_trap();
    logic [4:0] f;
    start_run();
    repeat (10) @(negedge clk);
    if_a.trap = 2'b10;
    @(negedge clk);
    if_a.trap = 2'b00;
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b01010 || if_a.trap_id !== 1'b1 || if_a.cycle_count !== 32'd11) begin
      failures++;
      $display("FAIL trap_drain flags=%b id=%0d cnt=%0d exp flags=01010 id=1 cnt=11",
               f, if_a.trap_id, if_a.cycle_count);
    end
    @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b10110 || if_a.trap_id !== 1'b1 || if_a.cycle_count !== 32'd11) begin
      failures++;
      $display("FAIL trap_final flags=%b id=%0d cnt=%0d exp flags=10110 id=1 cnt=11",
               f, if_a.trap_id, if_a.cycle_count);
    end
  endtask

  task automatic test_trap_priority();
    logic [4:0] f;
    start_run();
    repeat (3) @(negedge clk);
    if_e.trap = 2'b11;
    if_e.done = 1'b1;
    @(negedge clk);
    f = {if_e.cpu_reset, if_e.running, if_e.finished, if_e.status};
    checks++;
    if (f !== 5'b01010 || if_e.trap_id !== 1'b0 || if_e.cycle_count !== 32'd4) begin
      failures++;
      $display("FAIL prio_trap flags=%b id=%0d cnt=%0d exp flags=01010 id=0 cnt=4",
               f, if_e.trap_id, if_e.cycle_count);
    end
    if_e.trap = 2'b00;
    if_e.done = 1'b0;
    @(negedge clk);
    if_e.trap = 2'b10;
    if_e.done = 1'b1;
    @(negedge clk);
    f = {if_e.cpu_reset, if_e.running, if_e.finished, if_e.status};
    checks++;
    if (f !== 5'b01010 || if_e.trap_id !== 1'b0 || if_e.cycle_count !== 32'd6) begin
      failures++;
      $display("FAIL drain_ignore flags=%b id=%0d cnt=%0d exp flags=01010 id=0 cnt=6",
               f, if_e.trap_id, if_e.cycle_count);
    end
    if_e.trap = 2'b00;
    if_e.done = 1'b0;
    @(negedge clk);
    f = {if_e.cpu_reset, if_e.running, if_e.finished, if_e.status};
    checks++;
    if (f !== 5'b10110 || if_e.trap_id !== 1'b0 || if_e.cycle_count !== 32'd6) begin
      failures++;
      $display("FAIL drain3_final flags=%b id=%0d cnt=%0d exp flags=10110 id=0 cnt=6",
               f, if_e.trap_id, if_e.cycle_count);
    end
  endtask

  task automatic test_timeout();
    logic [4:0] f;
    start_run();
    repeat (37) @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b01000 || if_a.cycle_count !== 32'd37) begin
      failures++;
      $display("FAIL timeout_edge flags=%b cnt=%0d exp flags=01000 cnt=37", f, if_a.cycle_count);
    end
    @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b10111 || if_a.cycle_count !== 32'd37) begin
      failures++;
      $display("FAIL timeout_verdict flags=%b cnt=%0d exp flags=10111 cnt=37", f, if_a.cycle_count);
    end
  endtask

  task automatic test_no_timeout();
    logic [4:0] f;
    start_run();
    repeat (1000) @(negedge clk);
    f = {if_b.cpu_reset, if_b.running, if_b.finished, if_b.status};
    checks++;
    if (f !== 5'b01000 || if_b.cycle_count !== 32'd1000) begin
      failures++;
      $display("FAIL no_timeout flags=%b cnt=%0d exp flags=01000 cnt=1000", f, if_b.cycle_count);
    end
  endtask

  task automatic test_saturate();
    start_run();
    repeat (15) @(negedge clk);
    checks++;
    if (if_c.cycle_count !== 4'd15) begin
      failures++;
      $display("FAIL sat_reach cnt=%0d exp 15", if_c.cycle_count);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (if_c.cycle_count !== 4'd15 || if_c.running !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold cnt=%0d running=%b exp cnt=15 running=1",
               if_c.cycle_count, if_c.running);
    end
  endtask

  task automatic test_held_trap();
    logic [4:0] f;
    if_a.trap = 2'b01;
    start_run();
    repeat (2) @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b01000) begin
      failures++;
      $display("FAIL held_trap_ignored flags=%b exp 01000", f);
    end
    if_a.trap = 2'b00;
    repeat (2) @(negedge clk);
    if_a.trap = 2'b01;
    @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b01010 || if_a.trap_id !== 1'b0 || if_a.cycle_count !== 32'd5) begin
      failures++;
      $display("FAIL retrap flags=%b id=%0d cnt=%0d exp flags=01010 id=0 cnt=5",
               f, if_a.trap_id, if_a.cycle_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [4:0] f;
    rst = 1'b1;
    @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b10000 || if_a.trap_id !== 1'b0 || if_a.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL mid_drain_reset flags=%b id=%0d cnt=%0d exp flags=10000 id=0 cnt=0",
               f, if_a.trap_id, if_a.cycle_count);
    end
    if_a.trap = 2'b00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b01000 || if_a.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL rerun_entry flags=%b cnt=%0d exp flags=01000 cnt=0", f, if_a.cycle_count);
    end
    repeat (2) @(negedge clk);
    if_a.done = 1'b1;
    @(negedge clk);
    if_a.done = 1'b0;
    f = {if_a.cpu_reset, if_a.running, if_a.finished, if_a.status};
    checks++;
    if (f !== 5'b10101 || if_a.cycle_count !== 32'd2) begin
      failures++;
      $display("FAIL rerun_done flags=%b cnt=%0d exp flags=10101 cnt=2", f, if_a.cycle_count);
    end
  endtask

  task automatic test_no_drain();
    logic [4:0] f;
    start_run();
    repeat (4) @(negedge clk);
    if_d.trap = 1'b1;
    @(negedge clk);
    if_d.trap = 1'b0;
    f = {if_d.cpu_reset, if_d.running, if_d.finished, if_d.status};
    checks++;
    if (f !== 5'b10110 || if_d.trap_id !== 1'b0 || if_d.cycle_count !== 32'd4) begin
      failures++;
      $display("FAIL no_drain flags=%b id=%0d cnt=%0d exp flags=10110 id=0 cnt=4",
               f, if_d.trap_id, if_d.cycle_count);
    end
  endtask

  initial begin
    if_a.trap = '0; if_a.done = 1'b0;
    if_b.trap = '0; if_b.done = 1'b0;
    if_c.trap = '0; if_c.done = 1'b0;
    if_d.trap = '0; if_d.done = 1'b0;
    if_e.trap = '0; if_e.done = 1'b0;
    test_reset();
    test_done();
    test_trap();
    test_trap_priority();
    test_timeout();
    test_no_timeout();
    test_saturate();
    test_held_trap();
    test_reset_mid_drain();
    test_no_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
